// File: rtl/rv32_pkg.sv
// Shared RV32I definitions: datapath widths and the write-back entry layout
// carried from long-latency units to the register file.
package rv32_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/wbq_fifo.sv
// Circular storage for the write-back queue: entry array, pointers, occupancy
// count and per-entry valid bits (the valid bits feed the hazard compare).
module wbq_fifo
    import rv32_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic                    pop,
    input  wb_entry_t               push_entry,
    output wb_entry_t [DEPTH-1:0]   entries,
    output logic [DEPTH-1:0]        entry_valid,
    output logic [PTR_W-1:0]        rd_ptr,
    output logic [PTR_W:0]          count
);

    localparam logic [PTR_W:0] DEPTH_CNT = DEPTH[PTR_W:0];

    logic [PTR_W-1:0] wr_ptr;

    // Pointers wrap naturally because DEPTH is a power of two; the caller
    // never pushes when full or pops when empty, so slots never collide.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            entry_valid <= '0;
        end else begin
            if (push) begin
                entry_valid[wr_ptr] <= 1'b1;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop) begin
                entry_valid[rd_ptr] <= 1'b0;
                rd_ptr              <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            entries[wr_ptr] <= push_entry;
        end
    end

    count_in_range: assert property (@(posedge clk) disable iff (reset) count <= DEPTH_CNT);

endmodule

// File: rtl/rf_writeback_queue.sv
// Write-back queue feeding the RV32I regfile write port from long-latency units,
// with decode hazard detection. Optional same-cycle bypass: define WBQ_BYPASS_EN.
module rf_writeback_queue
    import rv32_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_rd,
    input  logic [31:0]      in_data,
    input  logic             cpu_we,
    output logic             rf_we,
    output logic [4:0]       rf_rd,
    output logic [31:0]      rf_rd_data,
    input  logic [4:0]       chk_rs1,
    input  logic [4:0]       chk_rs2,
    input  logic [4:0]       chk_rd,
    output logic             hazard,
    output logic [PTR_W:0]   count,
    output logic             empty
);

    localparam logic [PTR_W:0] DEPTH_CNT = DEPTH[PTR_W:0];

    wb_entry_t [DEPTH-1:0] entries;
    logic [DEPTH-1:0]      entry_valid;
    logic [PTR_W-1:0]      rd_ptr;
    wb_entry_t             head;
    wb_entry_t             push_entry;
    logic                  push;
    logic                  pop;
    logic                  bypass;

    assign empty      = (count == '0);
    assign in_ready   = (count != DEPTH_CNT);
    assign head       = entries[rd_ptr];
    assign push_entry = '{rd: in_rd, data: in_data};
    assign pop        = !empty && !cpu_we;

`ifdef WBQ_BYPASS_EN
    assign bypass = empty && in_valid && (in_rd != '0) && !cpu_we;
`else
    assign bypass = 1'b0;
`endif

    // Writes to x0 complete the handshake but are dropped; bypassed results never land in storage.
    assign push = in_valid && in_ready && (in_rd != '0) && !bypass;

    wbq_fifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push        (push),
        .pop         (pop),
        .push_entry  (push_entry),
        .entries     (entries),
        .entry_valid (entry_valid),
        .rd_ptr      (rd_ptr),
        .count       (count)
    );

    // Head drives the port whenever present (even while cpu_we holds it off); zeros when idle.
    always_comb begin
        rf_we      = pop || bypass;
        rf_rd      = '0;
        rf_rd_data = '0;
        if (!empty) begin
            rf_rd      = head.rd;
            rf_rd_data = head.data;
        end else if (bypass) begin
            rf_rd      = in_rd;
            rf_rd_data = in_data;
        end
    end

    // The entry being drained this cycle is still valid here, so it still raises a hazard.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i] &&
                ((chk_rs1 != '0 && entries[i].rd == chk_rs1) ||
                 (chk_rs2 != '0 && entries[i].rd == chk_rs2) ||
                 (chk_rd  != '0 && entries[i].rd == chk_rd))) begin
                hazard = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rf_writeback_queue.sv
// Self-checking bench for rf_writeback_queue: directed scenarios then random
// traffic, compared each cycle against a queue-based reference model.
module tb_rf_writeback_queue;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic [31:0] in_data;
    logic        cpu_we;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_rd_data;
    logic [4:0]  chk_rs1;
    logic [4:0]  chk_rs2;
    logic [4:0]  chk_rd;
    logic        hazard;
    logic [2:0]  count;
    logic        empty;

    int checks = 0;
    int passes = 0;

    logic [36:0] model_q[$];

    rf_writeback_queue #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_rd      (in_rd),
        .in_data    (in_data),
        .cpu_we     (cpu_we),
        .rf_we      (rf_we),
        .rf_rd      (rf_rd),
        .rf_rd_data (rf_rd_data),
        .chk_rs1    (chk_rs1),
        .chk_rs2    (chk_rs2),
        .chk_rd     (chk_rd),
        .hazard     (hazard),
        .count      (count),
        .empty      (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at %0t", tag, actual, expected, $time);
    endtask

    function automatic logic regHit(input logic [4:0] r, input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] cd);
        return (s1 != 0 && r == s1) || (s2 != 0 && r == s2) || (cd != 0 && r == cd);
    endfunction

    // One clock cycle: drive inputs, compare outputs against the model, clock, update the model.
    task automatic applyStimulus(input logic rst, input logic v, input logic [4:0] rd, input logic [31:0] d,
                                 input logic cw, input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] cd);
        int          pre_size;
        logic        exp_byp;
        logic        exp_we;
        logic        exp_haz;
        logic [36:0] exp_port;
        reset    = rst;
        in_valid = v;
        in_rd    = rd;
        in_data  = d;
        cpu_we   = cw;
        chk_rs1  = s1;
        chk_rs2  = s2;
        chk_rd   = cd;
        #1;
        pre_size = model_q.size();
        exp_byp  = 1'b0;
`ifdef WBQ_BYPASS_EN
        exp_byp  = (pre_size == 0) && v && (rd != 0) && !cw;
`endif
        exp_we   = (pre_size != 0 && !cw) || exp_byp;
        exp_haz  = 1'b0;
        foreach (model_q[i]) if (regHit(model_q[i][36:32], s1, s2, cd)) exp_haz = 1'b1;
        if (pre_size != 0) exp_port = model_q[0];
        else if (exp_byp)  exp_port = {rd, d};
        else               exp_port = '0;

        checkOutput("count",    64'(count),    64'(pre_size));
        checkOutput("empty",    64'(empty),    64'(pre_size == 0));
        checkOutput("in_ready", 64'(in_ready), 64'(pre_size < DEPTH));
        checkOutput("rf_we",    64'(rf_we),    64'(exp_we));
        checkOutput("hazard",   64'(hazard),   64'(exp_haz));
        if (exp_we || pre_size == 0) begin
            checkOutput("rf_rd",      64'(rf_rd),      64'(exp_port[36:32]));
            checkOutput("rf_rd_data", 64'(rf_rd_data), 64'(exp_port[31:0]));
        end

        @(posedge clk);
        if (rst) begin
            model_q.delete();
        end else begin
            if (pre_size != 0 && !cw) void'(model_q.pop_front());
            if (v && pre_size < DEPTH && rd != 0 && !exp_byp) model_q.push_back({rd, d});
        end
        #1;
    endtask

    task automatic idle(input logic cw);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, cw, 5'd0, 5'd0, 5'd0);
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_rd    = '0;
        in_data  = '0;
        cpu_we   = 1'b0;
        chk_rs1  = '0;
        chk_rs2  = '0;
        chk_rd   = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset then idle
        idle(1'b0);
        idle(1'b0);

        // Single write
        applyStimulus(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0, 5'd0);
        idle(1'b0);
        idle(1'b0);

        // Fill under cpu_we, attempt a fifth push, then drain in order
        for (int i = 1; i <= 5; i++)
            applyStimulus(1'b0, 1'b1, 5'(i), 32'(i * 32'h11), 1'b1, 5'd0, 5'd0, 5'd0);
        for (int i = 0; i < 5; i++) idle(1'b0);

        // Stall arbitration
        applyStimulus(1'b0, 1'b1, 5'd7, 32'h0000_0777, 1'b1, 5'd0, 5'd0, 5'd0);
        idle(1'b1);
        idle(1'b0);
        idle(1'b0);

        // Hazard and x0
        applyStimulus(1'b0, 1'b1, 5'd9, 32'h0000_0999, 1'b1, 5'd0, 5'd0, 5'd0);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd3, 5'd4);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 5'd0, 5'd4);
        applyStimulus(1'b0, 1'b1, 5'd0, 32'hBAD0_0000, 1'b1, 5'd0, 5'd0, 5'd9);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9, 5'd0);
        idle(1'b0);

        // Streaming with simultaneous push and pop across pointer wrap
        for (int i = 0; i < 10; i++)
            applyStimulus(1'b0, 1'b1, 5'(10 + i), 32'hA000_0000 + 32'(i), 1'b0, 5'(10 + i), 5'd0, 5'd0);
        idle(1'b0);
        idle(1'b0);

        // Reset mid-drain
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b0, 1'b1, 5'(20 + i), 32'hC000_0000 + 32'(i), 1'b1, 5'd0, 5'd0, 5'd0);
        applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd21, 5'd0, 5'd0);
        idle(1'b0);

        // Random traffic
        for (int i = 0; i < 500; i++)
            applyStimulus(1'($urandom_range(0, 99) == 0),
                          1'($urandom_range(0, 3) != 0),
                          5'($urandom_range(0, 7)),
                          $urandom(),
                          1'($urandom_range(0, 2) == 0),
                          5'($urandom_range(0, 7)),
                          5'($urandom_range(0, 7)),
                          5'($urandom_range(0, 7)));
        for (int i = 0; i < 6; i++) idle(1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
